gtech_pad_in_ctrl: RTL and testbench
====================================

# gtech_pad_in_ctrl

Input-pad conditioning and event controller between a bank of N_PADS `GTECH_INBUF` outputs and core logic. Per pad, it synchronises the buffered pad level, debounces it with a programmable threshold, and detects qualified edges. A round-robin arbiter then serialises pending edge events to a single valid/ready consumer and raises an interrupt. One instance serves one pad bank.

## Interface
Parameters:
- N_PADS, 8, number of pads handled; 2..32
- SYNC_STAGES, 2, synchroniser flops per pad; ≥2
- THR_W, 8, debounce threshold/counter width

Ports:
- CLK  in  1  sole clock
- RST  in  1  asynchronous, active-high reset
- DATA_IN  in  N_PADS  raw levels from `GTECH_INBUF` DATA_IN outputs; asynchronous to CLK
- CFG_THR  in  THR_W  debounce threshold in cycles; shared by all pads; 0 behaves as 1
- CFG_RISE_EN  in  N_PADS  per-pad rising-edge event enable
- CFG_FALL_EN  in  N_PADS  per-pad falling-edge event enable
- DATA_OUT  out  N_PADS  debounced stable levels
- EVT_VALID  out  1  event presented
- EVT_READY  in  1  consumer accepts event
- EVT_IDX  out  $clog2(N_PADS)  pad index of presented event
- EVT_RISE  out  1  1 = rising edge, 0 = falling edge
- IRQ  out  1  registered OR of all pending bits
- OVF  out  1  sticky: an edge hit a pad whose event was still pending
- OVF_CLR  in  1  single-cycle pulse that clears OVF

## Operation
- Reset values: sync chains, DATA_OUT, counters, pending, EVT_VALID, EVT_IDX, EVT_RISE, IRQ and OVF all 0. RR pointer starts so that pad 0 has highest priority.
- Debounce, per pad, with s = synchroniser output:
  - If s == DATA_OUT[i], the counter clears.
  - Otherwise the counter increments. When the counter reaches max(CFG_THR,1)-1, DATA_OUT[i] takes s and the counter clears.
  - A glitch shorter than the threshold leaves DATA_OUT unchanged.
- Edge qualification: on the edge where DATA_OUT[i] updates, pending[i] sets and rise[i] records the new level, if the matching enable bit is 1.
  - If pending[i] was already set, OVF sets and rise[i] is overwritten with the newest edge.
- Arbiter states:
  - IDLE: if any bit is pending, register the first pending pad after the last-granted index (wrap-around), load EVT_IDX/EVT_RISE, and go to PRESENT.
  - PRESENT: EVT_VALID=1. EVT_IDX/EVT_RISE hold until EVT_VALID&EVT_READY. On that edge, pending[EVT_IDX] clears, the RR pointer advances to EVT_IDX, and the state returns to IDLE.
- Simultaneous handshake and new edge on the same pad: the set wins. Pending stays 1 with the new rise value, and OVF does not set.
- Changing CFG_* takes effect next edge. Clearing an enable bit does not clear an existing pending bit.
- OVF_CLR and an OVF set in the same cycle: set wins.
- RST mid-operation discards all pending events and any in-flight event immediately, with no handshake.

## Timing
- DATA_IN change to DATA_OUT: SYNC_STAGES + max(CFG_THR,1) cycles, for a stable input.
- DATA_OUT update to EVT_VALID: 1 cycle, if the arbiter is idle.
- DATA_OUT update to IRQ: 1 cycle.
- Throughput: one event per 2 cycles. A mandatory IDLE bubble follows each handshake.
- EVT_VALID never drops without a handshake, except on RST.
- All outputs are registered. There is no combinational path from EVT_READY to EVT_VALID or EVT_IDX.

## Structure
- Package `gtech_pad_pkg` holds:
  - default constants N_PADS_DEF, SYNC_STAGES_DEF, THR_W_DEF
  - arbiter state encoding: IDLE=1'b0, PRESENT=1'b1
  - an index-width helper function
- Sub-module `gtech_pad_filter` contains one pad's synchroniser, debounce counter and edge strobe (outputs: level, rise_strb, fall_strb). It is instantiated N_PADS times by generate.
- The top level holds the pending/rise/OVF registers, RR arbiter and IRQ.

## Test plan
- Reset: assert RST mid-PRESENT with pending=8'hA5. Required: all outputs 0 asynchronously, and no event after release.
- Debounce: CFG_THR=4, SYNC_STAGES=2. A 3-cycle high pulse on pad 2 gives DATA_OUT unchanged and no event. A steady high gives DATA_OUT[2]=1 exactly 6 cycles after DATA_IN, then EVT_VALID 1 cycle later with IDX=2, RISE=1.
- Round-robin: pads 1, 3, 6 become pending in the same cycle, with EVT_READY tied 1. Required: events in order 1, 3, 6, each 2 cycles apart. A further re-pend on pad 1 is served after 6.
- Backpressure: hold EVT_READY=0 for 20 cycles. Required: EVT_VALID/IDX/RISE constant. Releasing READY completes exactly one handshake.
- Overflow: pad 0 rises (pending), then falls before it is serviced. Required: OVF=1, and the delivered event is IDX=0, RISE=0. OVF_CLR returns OVF to 0 the next cycle.
- Masks: CFG_RISE_EN=0, CFG_FALL_EN=8'hFF, and pad 4 toggles high then low. Required: only one event, RISE=0. IRQ is 1 exactly while pending[4]=1, delayed 1 cycle.

Source files
------------

// File: rtl/gtech_pad_pkg.sv
// Shared constants, arbiter state encoding and helpers for the pad-input controller.
package gtech_pad_pkg;

  localparam int N_PADS_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int THR_W_DEF       = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } arb_state_t;

  // Width of an index into a bank of n pads (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gtech_pad_filter.sv
// One pad: synchroniser chain, debounce counter and qualified-edge strobes.
module gtech_pad_filter
  import gtech_pad_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int THR_W       = THR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [THR_W-1:0] cfg_thr,
  output logic             level,
  output logic             rise_strb,
  output logic             fall_strb
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [THR_W-1:0]       cnt_reg;
  logic                   level_reg;
  logic                   sync_out;
  logic                   differs;
  logic                   thr_hit;
  logic [THR_W-1:0]       thr_last;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign differs  = (sync_out != level_reg);
  // A threshold of 0 is treated as 1, so the terminal count never wraps.
  assign thr_last = (cfg_thr == '0) ? '0 : (cfg_thr - THR_W'(1));
  assign thr_hit  = differs && (cnt_reg == thr_last);

  // Shift the asynchronous pad level through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '0;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
  end

  // Count consecutive mismatch cycles and commit the new level at the threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else if (!differs || thr_hit) begin
      cnt_reg <= '0;
      if (thr_hit) level_reg <= sync_out;
    end else begin
      cnt_reg <= cnt_reg + THR_W'(1);
    end
  end

  // Strobes coincide with the clock edge on which the level register updates.
  assign level     = level_reg;
  assign rise_strb = thr_hit & sync_out;
  assign fall_strb = thr_hit & ~sync_out;

endmodule

// File: rtl/gtech_pad_in_ctrl.sv
// Pad-bank conditioner: per-pad filters, pending/overflow tracking, round-robin
// event arbiter with valid/ready output and registered interrupt.
module gtech_pad_in_ctrl
  import gtech_pad_pkg::*;
#(
  parameter int  N_PADS      = N_PADS_DEF,
  parameter int  SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int  THR_W       = THR_W_DEF,
  localparam int IDX_W       = idx_width(N_PADS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_PADS-1:0] DATA_IN,
  input  logic [THR_W-1:0]  CFG_THR,
  input  logic [N_PADS-1:0] CFG_RISE_EN,
  input  logic [N_PADS-1:0] CFG_FALL_EN,
  output logic [N_PADS-1:0] DATA_OUT,
  output logic              EVT_VALID,
  input  logic              EVT_READY,
  output logic [IDX_W-1:0]  EVT_IDX,
  output logic              EVT_RISE,
  output logic              IRQ,
  output logic              OVF,
  input  logic              OVF_CLR
);

  logic [N_PADS-1:0] level;
  logic [N_PADS-1:0] rise_strb;
  logic [N_PADS-1:0] fall_strb;
  logic [N_PADS-1:0] qual;
  logic [N_PADS-1:0] clr_vec;
  logic [N_PADS-1:0] pend_reg, pend_next;
  logic [N_PADS-1:0] rise_reg, rise_next;
  logic              ovf_reg, ovf_next, ovf_hit;
  logic              irq_reg;
  logic              hs;

  arb_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              evt_rise_reg, evt_rise_next;
  logic [IDX_W-1:0]  rr_idx, hi_idx, lo_idx;
  logic              hi_found, lo_found;

  assign hs = (state_reg == PRESENT) && EVT_READY;

  genvar gi;
  generate
    for (gi = 0; gi < N_PADS; gi++) begin : g_pad
      gtech_pad_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .THR_W      (THR_W)
      ) u_filter (
        .clk      (CLK),
        .rst      (RST),
        .din      (DATA_IN[gi]),
        .cfg_thr  (CFG_THR),
        .level    (level[gi]),
        .rise_strb(rise_strb[gi]),
        .fall_strb(fall_strb[gi])
      );
      // Pad served by the handshake completing on this edge.
      assign clr_vec[gi] = hs && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // A new qualified edge outranks a same-cycle clear, so it never counts as overflow.
  assign qual      = (rise_strb & CFG_RISE_EN) | (fall_strb & CFG_FALL_EN);
  assign pend_next = qual | (pend_reg & ~clr_vec);
  assign rise_next = (qual & rise_strb) | (~qual & rise_reg);
  assign ovf_hit   = |(qual & pend_reg & ~clr_vec);
  assign ovf_next  = (ovf_reg & ~OVF_CLR) | ovf_hit;

  // Pending/rise bookkeeping, sticky overflow and interrupt.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_reg <= '0;
      rise_reg <= '0;
      ovf_reg  <= 1'b0;
      irq_reg  <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      rise_reg <= rise_next;
      ovf_reg  <= ovf_next;
      irq_reg  <= |pend_reg;
    end
  end

  // Round-robin search: lowest pending index above the pointer, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = N_PADS - 1; j >= 0; j--) begin
      if (pend_reg[j]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(j);
        if (IDX_W'(j) > ptr_reg) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(j);
        end
      end
    end
    rr_idx = hi_found ? hi_idx : lo_idx;
  end

  // Arbiter next state: capture an event in IDLE, hold it in PRESENT until accepted.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    idx_next      = idx_reg;
    evt_rise_next = evt_rise_reg;
    case (state_reg)
      IDLE: begin
        if (lo_found) begin
          idx_next      = rr_idx;
          evt_rise_next = rise_reg[rr_idx];
          state_next    = PRESENT;
        end
      end
      PRESENT: begin
        if (EVT_READY) begin
          ptr_next   = idx_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbiter state register; the pointer starts so that pad 0 wins first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      ptr_reg      <= IDX_W'(N_PADS - 1);
      idx_reg      <= '0;
      evt_rise_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      idx_reg      <= idx_next;
      evt_rise_reg <= evt_rise_next;
    end
  end

  assign DATA_OUT  = level;
  assign EVT_VALID = (state_reg == PRESENT);
  assign EVT_IDX   = idx_reg;
  assign EVT_RISE  = evt_rise_reg;
  assign IRQ       = irq_reg;
  assign OVF       = ovf_reg;

endmodule

// File: tb/tb_gtech_pad_in_ctrl.sv
// Bench for gtech_pad_in_ctrl: debounce latency table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_gtech_pad_in_ctrl;

  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int TW   = 8;
  localparam int IW   = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  DATA_IN = '0;
  logic [TW-1:0] CFG_THR = TW'(1);
  logic [N-1:0]  CFG_RISE_EN = '1;
  logic [N-1:0]  CFG_FALL_EN = '1;
  logic [N-1:0]  DATA_OUT;
  logic          EVT_VALID;
  logic          EVT_READY = 1'b1;
  logic [IW-1:0] EVT_IDX;
  logic          EVT_RISE;
  logic          IRQ;
  logic          OVF;
  logic          OVF_CLR = 1'b0;

  gtech_pad_in_ctrl #(.N_PADS(N), .SYNC_STAGES(SYNC), .THR_W(TW)) dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .CFG_THR(CFG_THR),
    .CFG_RISE_EN(CFG_RISE_EN), .CFG_FALL_EN(CFG_FALL_EN), .DATA_OUT(DATA_OUT),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_IDX(EVT_IDX),
    .EVT_RISE(EVT_RISE), .IRQ(IRQ), .OVF(OVF), .OVF_CLR(OVF_CLR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int hs_cnt = 0;

  // Reference model state
  logic [N-1:0] hist [0:SYNC];
  logic [N-1:0] lvl_m, pend_m, rise_m;
  int           run_m [N];
  logic         ovf_m;
  int           last_m;

  // Observed presentations (new EVT_VALID assertions)
  int   pq_idx [$];
  int   pq_cyc [$];
  logic pq_rise [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= SYNC; k++) hist[k] = '0;
    for (int i = 0; i < N; i++) run_m[i] = 0;
    lvl_m  = '0;
    pend_m = '0;
    rise_m = '0;
    ovf_m  = 1'b0;
    last_m = N - 1;
  endtask

  // First pending pad after 'last', wrapping; -1 when nothing is pending.
  function automatic int rr_pick(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (p[j]) return j;
    end
    return -1;
  endfunction

  // One clock edge with the currently driven inputs, then model update and checks.
  task automatic step();
    logic          vb, rb, hs, hit, s, qual, served;
    logic [IW-1:0] ib;
    logic [N-1:0]  pp, pr;
    int            thr_e, exp_i;
    vb = EVT_VALID; ib = EVT_IDX; rb = EVT_RISE;
    pp = pend_m;    pr = rise_m;
    hs = vb & EVT_READY;
    for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = DATA_IN;
    @(posedge CLK);
    #1;
    cyc++;
    thr_e = (CFG_THR == '0) ? 1 : int'(CFG_THR);
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = hist[SYNC][i];
      qual = 1'b0;
      if (s !== lvl_m[i]) begin
        run_m[i]++;
        if (run_m[i] >= thr_e) begin
          lvl_m[i] = s;
          run_m[i] = 0;
          qual = s ? CFG_RISE_EN[i] : CFG_FALL_EN[i];
        end
      end else begin
        run_m[i] = 0;
      end
      served = hs && (int'(ib) == i);
      if (qual) begin
        if (pend_m[i] && !served) hit = 1'b1;
        pend_m[i] = 1'b1;
        rise_m[i] = s;
      end else if (served) begin
        pend_m[i] = 1'b0;
      end
    end
    if (hs) begin
      last_m = int'(ib);
      hs_cnt++;
      $display("evt pad=%0d rise=%0d cycle=%0d", ib, rb, cyc);
    end
    ovf_m = (ovf_m & ~OVF_CLR) | hit;
    chk("data_out", 32'(DATA_OUT), 32'(lvl_m));
    chk("irq", 32'(IRQ), 32'(|pp));
    chk("ovf", 32'(OVF), 32'(ovf_m));
    if (vb && !hs) begin
      chk("hold_valid", 32'(EVT_VALID), 1);
      chk("hold_idx", 32'(EVT_IDX), 32'(ib));
      chk("hold_rise", 32'(EVT_RISE), 32'(rb));
    end else if (vb && hs) begin
      chk("bubble", 32'(EVT_VALID), 0);
    end else begin
      exp_i = rr_pick(pp, last_m);
      if (exp_i < 0) begin
        chk("idle_valid", 32'(EVT_VALID), 0);
      end else begin
        chk("pres_valid", 32'(EVT_VALID), 1);
        chk("pres_idx", 32'(EVT_IDX), 32'(exp_i));
        chk("pres_rise", 32'(EVT_RISE), 32'(pr[exp_i]));
      end
    end
    if (EVT_VALID && !vb) begin
      pq_idx.push_back(int'(EVT_IDX));
      pq_cyc.push_back(cyc);
      pq_rise.push_back(EVT_RISE);
    end
  endtask

  task automatic settle();
    DATA_IN = '0; EVT_READY = 1'b1; OVF_CLR = 1'b0;
    repeat (40) step();
  endtask

  task automatic wait_pres(input int maxc, input string name);
    int base, k;
    base = pq_idx.size();
    k = 0;
    while (pq_idx.size() == base && k < maxc) begin
      step();
      k++;
    end
    chk(name, 32'(pq_idx.size() > base), 1);
  endtask

  typedef struct {
    int   thr;
    int   pad;
    logic lvl;
    int   lat;
  } deb_vec_t;

  deb_vec_t tab [6];

  initial begin
    int n, base, hs0;
    logic [IW-1:0] hold_i;
    logic hold_r;

    // Latency = SYNC stages + max(threshold,1)
    tab[0] = '{4, 2, 1'b1, 6};
    tab[1] = '{4, 2, 1'b0, 6};
    tab[2] = '{1, 5, 1'b1, 3};
    tab[3] = '{0, 5, 1'b0, 3};
    tab[4] = '{3, 7, 1'b1, 5};
    tab[5] = '{10, 7, 1'b0, 12};

    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_data_out", 32'(DATA_OUT), 0);
    chk("rst_valid", 32'(EVT_VALID), 0);
    chk("rst_idx", 32'(EVT_IDX), 0);
    chk("rst_rise", 32'(EVT_RISE), 0);
    chk("rst_irq", 32'(IRQ), 0);
    chk("rst_ovf", 32'(OVF), 0);

    // Round-robin: pads 1,3,6 together, pad 1 re-pends while 3 is served
    CFG_THR = TW'(1); EVT_READY = 1'b1;
    base = pq_idx.size();
    DATA_IN = 8'h4A;
    n = 0;
    while (pq_idx.size() < base + 4 && n < 40) begin
      step();
      n++;
      if (pq_idx.size() == base + 1 && DATA_IN[1]) DATA_IN[1] = 1'b0;
    end
    chk("rr_count", 32'(pq_idx.size() - base), 4);
    if (pq_idx.size() >= base + 4) begin
      chk("rr_first", 32'(pq_idx[base]), 1);
      chk("rr_second", 32'(pq_idx[base+1]), 3);
      chk("rr_third", 32'(pq_idx[base+2]), 6);
      chk("rr_repend", 32'(pq_idx[base+3]), 1);
      chk("rr_gap1", 32'(pq_cyc[base+1] - pq_cyc[base]), 2);
      chk("rr_gap2", 32'(pq_cyc[base+2] - pq_cyc[base+1]), 2);
      chk("rr_gap3", 32'(pq_cyc[base+3] - pq_cyc[base+2]), 2);
    end
    settle();

    // Glitch shorter than the threshold
    CFG_THR = TW'(4);
    base = pq_idx.size();
    DATA_IN[2] = 1'b1;
    repeat (3) step();
    DATA_IN[2] = 1'b0;
    repeat (10) step();
    chk("glitch_dout", 32'(DATA_OUT[2]), 0);
    chk("glitch_evt", 32'(pq_idx.size() - base), 0);

    // Debounce latency table
    for (int t = 0; t < 6; t++) begin
      CFG_THR = TW'(tab[t].thr);
      DATA_IN[tab[t].pad] = tab[t].lvl;
      n = 0;
      while (DATA_OUT[tab[t].pad] !== tab[t].lvl && n < 40) begin
        step();
        n++;
      end
      chk("deb_lat", 32'(n), 32'(tab[t].lat));
      step();
      chk("deb_valid", 32'(EVT_VALID), 1);
      chk("deb_idx", 32'(EVT_IDX), 32'(tab[t].pad));
      chk("deb_rise", 32'(EVT_RISE), 32'(tab[t].lvl));
      repeat (3) step();
    end
    CFG_THR = TW'(1);
    settle();

    // Backpressure: 20 cycles of READY=0, then exactly one handshake
    EVT_READY = 1'b0;
    DATA_IN[5] = 1'b1;
    wait_pres(20, "bp_present");
    hold_i = EVT_IDX;
    hold_r = EVT_RISE;
    chk("bp_idx", 32'(hold_i), 5);
    repeat (20) begin
      step();
      chk("bp_hold_v", 32'(EVT_VALID), 1);
      chk("bp_hold_i", 32'(EVT_IDX), 32'(hold_i));
      chk("bp_hold_r", 32'(EVT_RISE), 32'(hold_r));
    end
    hs0 = hs_cnt;
    EVT_READY = 1'b1;
    repeat (5) step();
    chk("bp_one_hs", 32'(hs_cnt - hs0), 1);
    settle();

    // Overflow: pad 0 rises then falls while pad 5 holds the arbiter
    EVT_READY = 1'b0;
    DATA_IN[5] = 1'b1;
    wait_pres(20, "ovf_block");
    DATA_IN[0] = 1'b1;
    repeat (5) step();
    DATA_IN[0] = 1'b0;
    repeat (5) step();
    chk("ovf_set", 32'(OVF), 1);
    EVT_READY = 1'b1;
    step();
    wait_pres(10, "ovf_deliver");
    chk("ovf_idx", 32'(pq_idx[pq_idx.size()-1]), 0);
    chk("ovf_rise", 32'(pq_rise[pq_rise.size()-1]), 0);
    step();
    OVF_CLR = 1'b1;
    step();
    OVF_CLR = 1'b0;
    chk("ovf_clr", 32'(OVF), 0);
    settle();

    // Masks: only the falling edge of pad 4 qualifies
    CFG_RISE_EN = '0;
    CFG_FALL_EN = 8'hFF;
    base = pq_idx.size();
    DATA_IN[4] = 1'b1;
    repeat (6) step();
    DATA_IN[4] = 1'b0;
    repeat (10) step();
    chk("mask_count", 32'(pq_idx.size() - base), 1);
    if (pq_idx.size() > base) begin
      chk("mask_idx", 32'(pq_idx[base]), 4);
      chk("mask_rise", 32'(pq_rise[base]), 0);
    end
    CFG_RISE_EN = '1;
    settle();

    // Reset while presenting with pending = 8'hA5
    EVT_READY = 1'b0;
    DATA_IN = 8'hA5;
    repeat (6) step();
    chk("pre_rst_irq", 32'(IRQ), 1);
    chk("pre_rst_valid", 32'(EVT_VALID), 1);
    chk("pre_rst_dout", 32'(DATA_OUT), 32'h0A5);
    #2;
    RST = 1'b1;
    DATA_IN = '0;
    #1;
    chk("arst_data_out", 32'(DATA_OUT), 0);
    chk("arst_valid", 32'(EVT_VALID), 0);
    chk("arst_idx", 32'(EVT_IDX), 0);
    chk("arst_rise", 32'(EVT_RISE), 0);
    chk("arst_irq", 32'(IRQ), 0);
    chk("arst_ovf", 32'(OVF), 0);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    EVT_READY = 1'b1;
    base = pq_idx.size();
    repeat (15) step();
    chk("post_rst_events", 32'(pq_idx.size() - base), 0);

    // Randomized traffic with thresholds 0, 1 and 3
    for (int ph = 0; ph < 3; ph++) begin
      settle();
      CFG_THR     = (ph == 0) ? TW'(0) : (ph == 1) ? TW'(1) : TW'(3);
      CFG_RISE_EN = N'($urandom);
      CFG_FALL_EN = N'($urandom);
      repeat (1500) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 7) == 0) DATA_IN[i] = ~DATA_IN[i];
        EVT_READY = 1'($urandom_range(0, 1));
        OVF_CLR   = ($urandom_range(0, 15) == 0);
        step();
      end
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
